// File: rtl/pipe_reg.sv
// pipe_reg: valid/ready pipeline register with optional two-entry skid buffer.
//    clk        rising-edge clock
//    clrn       asynchronous active-low reset
//    in_valid   upstream beat present on d
//    in_ready   block can accept a beat this cycle
//    d          upstream data
//    flush      synchronous discard of all held beats
//    out_valid  q holds a valid beat
//    out_ready  downstream takes q this cycle
//    q          head beat data (always the main entry register)
//    count      number of beats held (0..2)
module pipe_reg #(
   parameter int               WIDTH   = 32,
   parameter logic [WIDTH-1:0] RST_VAL = '0,
   parameter int               SKID    = 1
)(
   input  logic             clk,
   input  logic             clrn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] d,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] q,
   output logic [1:0]       count
);
   typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_FULL = 2'd1, ST_SKID = 2'd2} state_t;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d, skid_q, skid_d;
   logic             rdy_q, rdy_d;
   logic             accept, deliver;
   assign out_valid = state_q != ST_EMPTY;
   assign q         = main_q;
   assign count     = state_q;
   // rdy_q is low in reset and rises on the first edge after release; in
   // single-entry mode it only gates the combinational pass-through ready.
   assign in_ready  = (SKID != 0) ? rdy_q : rdy_q & (~out_valid | out_ready);
   assign accept    = in_valid & in_ready;
   assign deliver   = out_valid & out_ready;
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = ST_EMPTY;
         main_d  = RST_VAL;
         skid_d  = RST_VAL;
      end else begin
         case (state_q)
            ST_EMPTY: if (accept) begin
               state_d = ST_FULL;
               main_d  = d;
            end
            ST_FULL: if (accept && deliver) begin
               main_d = d;
            end else if (accept) begin
               state_d = ST_SKID;
               skid_d  = d;
            end else if (deliver) begin
               state_d = ST_EMPTY;
            end
            ST_SKID: if (deliver) begin
               state_d = ST_FULL;
               main_d  = skid_q;
            end
            default: state_d = ST_EMPTY;
         endcase
      end
      rdy_d = (SKID == 0) || (state_d != ST_SKID);
   end
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q <= ST_EMPTY;
         main_q  <= RST_VAL;
         skid_q  <= RST_VAL;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         rdy_q   <= rdy_d;
      end
   end
endmodule

// File: tb/tb_pipe_reg.sv
// tb_pipe_reg: directed vector bench for pipe_reg in skid and single-entry modes.
module tb_pipe_reg;
   localparam logic [31:0] R = 32'h5A5A_0000;
   logic        clk = 1'b0;
   logic        clrn = 1'b1;
   logic        iv_1 = 0, or_1 = 0, fl_1 = 0, ir_1, ov_1;
   logic [31:0] d_1 = 0, q_1;
   logic [1:0]  cnt_1;
   logic        iv_0 = 0, or_0 = 0, fl_0 = 0, ir_0, ov_0;
   logic [31:0] d_0 = 0, q_0;
   logic [1:0]  cnt_0;
   int          total = 0, passed = 0;
   always #5 clk = ~clk;
   pipe_reg #(.WIDTH(32), .RST_VAL(R), .SKID(1)) dut_1 (
      .clk(clk), .clrn(clrn), .in_valid(iv_1), .in_ready(ir_1), .d(d_1), .flush(fl_1),
      .out_valid(ov_1), .out_ready(or_1), .q(q_1), .count(cnt_1));
   pipe_reg #(.WIDTH(32), .RST_VAL(R), .SKID(0)) dut_0 (
      .clk(clk), .clrn(clrn), .in_valid(iv_0), .in_ready(ir_0), .d(d_0), .flush(fl_0),
      .out_valid(ov_0), .out_ready(or_0), .q(q_0), .count(cnt_0));
   typedef struct {
      logic        iv;
      logic [31:0] d;
      logic        ordy;
      logic        fl;
      logic        ov;
      logic [31:0] q;
      logic [1:0]  cnt;
      logic        ir;
   } vec_t;
   vec_t vecs[16];
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      else passed++;
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   initial begin
      int sent_1, rcv_1, sent_0, rcv_0;
      logic a_1, a_0, dl_1, dl_0;
      vecs[0]  = '{1'b1, 32'h11, 1'b1, 1'b0, 1'b1, 32'h11, 2'd1, 1'b1};
      vecs[1]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h11, 2'd0, 1'b1};
      vecs[2]  = '{1'b1, 32'hA1, 1'b0, 1'b0, 1'b1, 32'hA1, 2'd1, 1'b1};
      vecs[3]  = '{1'b1, 32'hA2, 1'b0, 1'b0, 1'b1, 32'hA1, 2'd2, 1'b0};
      vecs[4]  = '{1'b1, 32'hA3, 1'b0, 1'b0, 1'b1, 32'hA1, 2'd2, 1'b0};
      vecs[5]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 32'hA2, 2'd1, 1'b1};
      vecs[6]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'hA2, 2'd0, 1'b1};
      vecs[7]  = '{1'b1, 32'hB1, 1'b1, 1'b0, 1'b1, 32'hB1, 2'd1, 1'b1};
      vecs[8]  = '{1'b1, 32'hB2, 1'b0, 1'b0, 1'b1, 32'hB1, 2'd2, 1'b0};
      vecs[9]  = '{1'b1, 32'hFF, 1'b0, 1'b1, 1'b0, R,      2'd0, 1'b1};
      vecs[10] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, R,      2'd0, 1'b1};
      vecs[11] = '{1'b1, 32'hC1, 1'b0, 1'b0, 1'b1, 32'hC1, 2'd1, 1'b1};
      vecs[12] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b0, R,      2'd0, 1'b1};
      vecs[13] = '{1'b1, 32'hC2, 1'b0, 1'b0, 1'b1, 32'hC2, 2'd1, 1'b1};
      vecs[14] = '{1'b1, 32'hC3, 1'b1, 1'b0, 1'b1, 32'hC3, 2'd1, 1'b1};
      vecs[15] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 32'hC3, 2'd1, 1'b1};
      #1 clrn = 1'b0;
      #1;
      chk("rst_ov1", ov_1, 0); chk("rst_q1", q_1, R); chk("rst_cnt1", cnt_1, 0); chk("rst_ir1", ir_1, 0);
      chk("rst_ov0", ov_0, 0); chk("rst_q0", q_0, R); chk("rst_cnt0", cnt_0, 0); chk("rst_ir0", ir_0, 0);
      #20 clrn = 1'b1;
      #1;
      chk("rel_ir1", ir_1, 0); chk("rel_ir0", ir_0, 0);
      tick();
      chk("up_ir1", ir_1, 1); chk("up_ir0", ir_0, 1);
      for (int i = 0; i < 16; i++) begin
         iv_1 = vecs[i].iv; d_1 = vecs[i].d; or_1 = vecs[i].ordy; fl_1 = vecs[i].fl;
         tick();
         chk($sformatf("v%0d_ov", i), ov_1, vecs[i].ov);
         chk($sformatf("v%0d_q", i), q_1, vecs[i].q);
         chk($sformatf("v%0d_cnt", i), cnt_1, vecs[i].cnt);
         chk($sformatf("v%0d_ir", i), ir_1, vecs[i].ir);
      end
      iv_1 = 0; or_1 = 0; fl_1 = 1;
      iv_0 = 1; d_0 = 32'h10; or_0 = 0;
      #1 chk("s0_ir_empty", ir_0, 1);
      tick();
      fl_1 = 0;
      chk("s0_ov_a", ov_0, 1); chk("s0_q_a", q_0, 32'h10); chk("s0_cnt_a", cnt_0, 1);
      chk("fl_cnt1", cnt_1, 0);
      iv_0 = 1; d_0 = 32'h20; or_0 = 1;
      #1 chk("s0_ir_pass", ir_0, 1);
      tick();
      chk("s0_ov_b", ov_0, 1); chk("s0_q_b", q_0, 32'h20); chk("s0_cnt_b", cnt_0, 1);
      iv_0 = 1; d_0 = 32'h30; or_0 = 0;
      #1 chk("s0_ir_block", ir_0, 0);
      tick();
      chk("s0_q_c", q_0, 32'h20); chk("s0_cnt_c", cnt_0, 1);
      iv_0 = 0; or_0 = 1;
      tick();
      chk("s0_ov_d", ov_0, 0); chk("s0_cnt_d", cnt_0, 0);
      sent_1 = 0; rcv_1 = 0; sent_0 = 0; rcv_0 = 0;
      for (int cyc = 0; cyc < 2000 && (rcv_1 < 100 || rcv_0 < 100); cyc++) begin
         iv_1 = sent_1 < 100; d_1 = 32'(sent_1); or_1 = 1'($urandom_range(0, 1));
         iv_0 = sent_0 < 100; d_0 = 32'(sent_0); or_0 = 1'($urandom_range(0, 1));
         #1;
         a_1 = iv_1 & ir_1; dl_1 = ov_1 & or_1;
         a_0 = iv_0 & ir_0; dl_0 = ov_0 & or_0;
         if (dl_1) begin chk("stream1", q_1, 32'(rcv_1)); rcv_1++; end
         if (dl_0) begin chk("stream0", q_0, 32'(rcv_0)); rcv_0++; end
         if (cnt_0 > 2'd1) chk("s0_cnt_max", cnt_0, 1);
         tick();
         if (a_1) sent_1++;
         if (a_0) sent_0++;
      end
      chk("stream1_total", rcv_1, 100); chk("stream0_total", rcv_0, 100);
      iv_1 = 1; d_1 = 32'h77; or_1 = 0; iv_0 = 1; d_0 = 32'h66; or_0 = 0;
      tick();
      chk("pre_cnt1", cnt_1, 1); chk("pre_cnt0", cnt_0, 1);
      iv_1 = 0; iv_0 = 0;
      #1 clrn = 1'b0;
      #1;
      chk("ar_ov1", ov_1, 0); chk("ar_q1", q_1, R); chk("ar_cnt1", cnt_1, 0); chk("ar_ir1", ir_1, 0);
      chk("ar_ov0", ov_0, 0); chk("ar_q0", q_0, R); chk("ar_cnt0", cnt_0, 0); chk("ar_ir0", ir_0, 0);
      #1 clrn = 1'b1;
      chk("ar_rel_ir1", ir_1, 0); chk("ar_rel_ir0", ir_0, 0);
      tick();
      chk("ar_up_ir1", ir_1, 1); chk("ar_up_ir0", ir_0, 1);
      chk("ar_up_ov1", ov_1, 0); chk("ar_up_ov0", ov_0, 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/pipe_reg.md
PIPE_REG -- requirements
Module: pipe_reg

Interface
REQ-001 Parameter WIDTH, default 32, data path width in bits (1..64).
REQ-002 Parameter RST_VAL, default 0, value of q after reset or flush (WIDTH bits).
REQ-003 Parameter SKID, default 1, 1 = two-entry skid mode, 0 = single-entry mode.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 clrn  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  upstream presents a beat on d.
REQ-007 in_ready  output  1  block can accept a beat this cycle.
REQ-008 d  input  WIDTH  upstream data.
REQ-009 flush  input  1  synchronous discard of all held beats.
REQ-010 out_valid  output  1  q holds a valid beat.
REQ-011 out_ready  input  1  downstream takes q this cycle.
REQ-012 q  output  WIDTH  head beat data.
REQ-013 count  output  2  number of beats held (0..2).

Function
REQ-014 Accept = in_valid & in_ready at a rising edge; deliver = out_valid & out_ready at a rising edge.
REQ-015 State machine states: EMPTY (count 0), FULL (count 1, main entry valid), SKID (count 2, main and skid entries valid).
REQ-016 out_valid SHALL be high in FULL and SKID only; q SHALL always be the main entry register output (no combinational path d->q).
REQ-017 EMPTY: accept -> FULL, main <= d; no accept -> stay EMPTY.
REQ-018 FULL: accept & deliver -> FULL, main <= d; accept only -> SKID, skid <= d; deliver only -> EMPTY; neither -> hold.
REQ-019 SKID: deliver -> FULL, main <= skid; no deliver -> hold both entries.
REQ-020 SKID=1: in_ready SHALL be a registered signal, high in EMPTY and FULL, low in SKID; no combinational path out_ready->in_ready.
REQ-021 SKID=0: SKID state unreachable; in_ready = ~out_valid | out_ready (combinational); count never exceeds 1.
REQ-022 Latency: beat accepted in EMPTY appears with out_valid high on the next cycle; throughput one beat per cycle while out_ready held high.
REQ-023 Beats SHALL leave in acceptance order; no beat duplicated or dropped except by flush.
REQ-024 flush has priority over accept and deliver: next state EMPTY, main and skid <= RST_VAL, count 0; a beat presented in the flush cycle is discarded.
REQ-025 Deliver with flush high counts as taken by downstream in that cycle; block does not re-present it.
REQ-026 Entry registers not written SHALL hold their value (no X propagation on idle cycles).

Reset
REQ-027 clrn low SHALL immediately (no clock) force state EMPTY, out_valid 0, count 0, q = RST_VAL, skid entry = RST_VAL.
REQ-028 During reset in_ready SHALL be 0; in_ready rises at the first rising clk edge after clrn deasserts (both modes).
REQ-029 Reset asserted mid-operation discards all held beats; no beat is delivered from before reset.
REQ-030 Power-on initial value of every register SHALL equal its reset value.

Verification
REQ-031 Reset then in_valid=1, d=0x00000011, out_ready=1 for one cycle -> next cycle out_valid=1, q=0x00000011, count=1.
REQ-032 SKID=1, out_ready=0, push 0xA1 then 0xA2 -> count=2, in_ready=0, q=0xA1; raise out_ready -> q=0xA2 next cycle, then out_valid=0.
REQ-033 Continuous stream 0..99, out_ready toggled pseudo-randomly -> output sequence exactly 0..99, no gaps or repeats.
REQ-034 count=2, flush=1 with in_valid=1, d=0xFF -> next cycle count=0, out_valid=0, q=RST_VAL; 0xFF never appears.
REQ-035 count=1, clrn pulled low between edges -> out_valid=0 and q=RST_VAL before next edge; in_ready=1 only after first edge following release.
REQ-036 SKID=0, out_valid=1, out_ready=1, in_valid=1 -> in_ready=1 same cycle, beat replaced, count stays 1.
